// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register file, carry flag and operand pipeline register feeding the ALU
module alu_operand_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    cmd_in,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] rd_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_cmd,
  output logic [DW-1:0] inA,
  output logic [DW-1:0] inB,
  output logic          sc_i,
  output logic [AW-1:0] rd_out,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_sc_en,
  input  logic          wb_sc
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {EMPTY, FULL} state_t;

  logic [DW-1:0] rf [DEPTH];
  logic          carry;
  state_t        state;
  logic [AW-1:0] ra_tag;
  logic [AW-1:0] rb_tag;

  logic          accept;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_next;
  logic          sc_next;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Operand selection forwards a same-cycle write-back so the bundle never captures a stale value
  always_comb begin
    a_next  = (wb_en && (wb_addr == ra_addr)) ? wb_data : rf[ra_addr];
    b_next  = (wb_en && (wb_addr == rb_addr)) ? wb_data : rf[rb_addr];
    sc_next = wb_sc_en ? wb_sc : carry;
  end

  // Register file: one write port, written whenever wb_en is set regardless of handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Carry flag written back from the ALU
  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (wb_sc_en) begin
      carry <= wb_sc;
    end
  end

  // Output pipeline register: load on accept, drain on consume, refresh held operands on write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      alu_cmd <= '0;
      inA     <= '0;
      inB     <= '0;
      sc_i    <= 1'b0;
      rd_out  <= '0;
      ra_tag  <= '0;
      rb_tag  <= '0;
    end else if (accept) begin
      state   <= FULL;
      alu_cmd <= cmd_in;
      inA     <= a_next;
      inB     <= b_next;
      sc_i    <= sc_next;
      rd_out  <= rd_in;
      ra_tag  <= ra_addr;
      rb_tag  <= rb_addr;
    end else if (state == FULL) begin
      if (out_ready) begin
        state <= EMPTY;
      end
      if (wb_en && (wb_addr == ra_tag)) begin
        inA <= wb_data;
      end
      if (wb_en && (wb_addr == rb_tag)) begin
        inB <= wb_data;
      end
      if (wb_sc_en) begin
        sc_i <= wb_sc;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage against an architectural model
module tb_alu_operand_stage;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    cmd_in, alu_cmd;
  logic [AW-1:0] ra_addr, rb_addr, rd_in, rd_out, wb_addr;
  logic [DW-1:0] inA, inB, wb_data;
  logic          sc_i, wb_en, wb_sc_en, wb_sc;

  always #5 clk = ~clk;

  alu_operand_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_in(cmd_in), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_cmd(alu_cmd),
    .inA(inA), .inB(inB), .sc_i(sc_i), .rd_out(rd_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_sc_en(wb_sc_en), .wb_sc(wb_sc)
  );

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rd;
  } op_t;

  // Architectural state: a held bundle always presents the current contents of its source registers
  logic [DW-1:0] m_rf [1 << AW];
  logic          m_carry;
  logic          m_full;
  op_t           q[$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge from the stimulus alone
  always @(posedge clk) begin
    logic acc;
    op_t  d;
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) m_rf[i] = '0;
      m_carry = 1'b0;
      m_full  = 1'b0;
      q.delete();
    end else begin
      acc = in_valid && (!m_full || out_ready);
      if (m_full && out_ready) begin
        d = q.pop_front();
        m_full = 1'b0;
      end
      if (acc) begin
        q.push_back('{cmd: cmd_in, ra: ra_addr, rb: rb_addr, rd: rd_in});
        m_full = 1'b1;
      end
      if (wb_en) m_rf[wb_addr] = wb_data;
      if (wb_sc_en) m_carry = wb_sc;
    end
  end

  // Monitor compares the presented bundle with the head of the scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_full || out_ready);
      chk("out_valid", out_valid, m_full);
      if (m_full && q.size() > 0) begin
        chk("alu_cmd", alu_cmd, q[0].cmd);
        chk("rd_out", rd_out, q[0].rd);
        chk("inA", inA, m_rf[q[0].ra]);
        chk("inB", inB, m_rf[q[0].rb]);
        chk("sc_i", sc_i, m_carry);
      end
    end
  end

  task automatic drive(input logic rst, input logic v, input logic [2:0] c,
                       input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                       input logic ordy, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic se, input logic s);
    reset = rst; in_valid = v; cmd_in = c; ra_addr = a; rb_addr = b; rd_in = d;
    out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd; wb_sc_en = se; wb_sc = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 3'd0, '0, '0, '0, ordy, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wb(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    drive(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b1, wa, wd, 1'b0, 1'b0);
  endtask

  int vcount;

  initial begin
    drive(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_inA", inA, 0);

    // Basic issue after write-back
    wb(3'd2, 8'h5A);
    wb(3'd3, 8'h11);
    drive(1'b0, 1'b1, 3'b111, 3'd2, 3'd3, 3'd4, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_inA", inA, 8'h5A);
    chk("basic_inB", inB, 8'h11);
    chk("basic_alu_cmd", alu_cmd, 3'b111);
    chk("basic_rd_out", rd_out, 4);

    // Same-cycle bypass, including ra == rb
    drive(1'b0, 1'b1, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b1, 3'd1, 8'hC3, 1'b0, 1'b0);
    @(negedge clk);
    chk("bypass_inA", inA, 8'hC3);
    chk("bypass_inB", inB, 8'hC3);

    // Stall with refresh of the held operand
    drive(1'b0, 1'b1, 3'd2, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_alu_cmd", alu_cmd, 3'd2);
    end
    drive(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b1, 3'd5, 8'h7E, 1'b0, 1'b0);
    @(negedge clk);
    chk("refresh_inA", inA, 8'h7E);
    chk("refresh_out_valid", out_valid, 1);
    idle(1'b1);

    // Back-to-back issue with no bubble
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 3'(i), 3'(i), 3'(i + 1), 3'(i + 2), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("b2b_valid_cycles", vcount, 4);
    idle(1'b1);

    // Carry write-back, then reset while FULL
    drive(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 3'd5, 3'd2, 3'd3, 3'd1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("carry_sc_i", sc_i, 1);
    drive(1'b1, 1'b1, 3'd6, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd1, 8'hFF, 1'b1, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sc_i", sc_i, 0);
    chk("rst_inA", inA, 0);
    chk("rst_alu_cmd", alu_cmd, 0);
    for (int r = 0; r < (1 << AW); r++) begin
      drive(1'b0, 1'b1, 3'd0, 3'(r), 3'(r), 3'd0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_reg_zero", inA, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 149) == 0), $urandom_range(0, 1), 3'($urandom),
            AW'($urandom), AW'($urandom), AW'($urandom), ($urandom_range(0, 9) < 7),
            $urandom_range(0, 1), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
